// File: rtl/sa_seq_ctrl_if.sv
// Signal bundle between the tile scheduler / result consumer and sa_seq_ctrl:
// tile command, skewed array strobes and the ofm drain handshake.
interface sa_seq_ctrl_if #(
    parameter int HEIGHT = 32,
    parameter int WIDTH  = 32,
    parameter int KWIDTH = 16
) ();
    localparam int RW = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;

    logic              start;
    logic [KWIDTH-1:0] k_len;
    logic              busy;
    logic              done;
    logic [HEIGHT-1:0] en_i;
    logic [HEIGHT-1:0] clr_i;
    logic [HEIGHT-1:0] mac_done;
    logic [WIDTH-1:0]  en_w;
    logic [WIDTH-1:0]  clr_w;
    logic [WIDTH-1:0]  en_o;
    logic [WIDTH-1:0]  clr_o;
    logic              out_valid;
    logic              out_ready;
    logic [RW-1:0]     out_row;

    modport master (
        input  start, k_len, out_ready,
        output busy, done, en_i, clr_i, mac_done, en_w, clr_w,
               en_o, clr_o, out_valid, out_row
    );

    modport slave (
        output start, k_len, out_ready,
        input  busy, done, en_i, clr_i, mac_done, en_w, clr_w,
               en_o, clr_o, out_valid, out_row
    );
endinterface

// File: rtl/sa_seq_ctrl.sv
// Control sequencer for an output-stationary bit-serial systolic MAC array:
// skewed operand strobes, pipeline flush, then ofm drain under valid/ready.
module sa_seq_ctrl #(
    parameter int HEIGHT = 32,
    parameter int WIDTH  = 32,
    parameter int PERIOD = 16,
    parameter int KWIDTH = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    sa_seq_ctrl_if.master bus
);
    localparam int D  = ((HEIGHT > WIDTH) ? HEIGHT : WIDTH) - 1;
    localparam int DP = (D > 0) ? D : 1;
    localparam int F  = HEIGHT + WIDTH - 2 + PERIOD;
    localparam int PW = (PERIOD > 1) ? $clog2(PERIOD) : 1;
    localparam int FW = $clog2(F + 1);
    localparam int RW = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;

    typedef enum logic [1:0] {IDLE, FEED, FLUSH, DRAIN} state_t;

    state_t            state_q, state_d;
    logic [KWIDTH-1:0] k_q, k_d, klast_q, klast_d;
    logic [PW-1:0]     p_q, p_d;
    logic [FW-1:0]     f_q, f_d;
    logic [RW-1:0]     row_q, row_d;
    logic              done_q, done_d, clro_q, clro_d;
    logic [DP-1:0]     ps_q, ps_d, pf_q, pf_d, pl_q, pl_d;
    logic              s, s_first, s_last, beat;
    logic [HEIGHT-1:0] en_i_c, clr_i_c, mac_done_c;
    logic [WIDTH-1:0]  en_w_c, clr_w_c;

    assign s       = (state_q == FEED) && (p_q == '0);
    assign s_first = s && (k_q == '0);
    assign s_last  = s && (k_q == klast_q);
    assign beat    = (state_q == DRAIN) && bus.out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            k_q     <= '0;
            klast_q <= '0;
            p_q     <= '0;
            f_q     <= '0;
            row_q   <= '0;
            done_q  <= 1'b0;
            clro_q  <= 1'b0;
            ps_q    <= '0;
            pf_q    <= '0;
            pl_q    <= '0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            klast_q <= klast_d;
            p_q     <= p_d;
            f_q     <= f_d;
            row_q   <= row_d;
            done_q  <= done_d;
            clro_q  <= clro_d;
            ps_q    <= ps_d;
            pf_q    <= pf_d;
            pl_q    <= pl_d;
        end
    end

    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        klast_d = klast_q;
        p_d     = p_q;
        f_d     = f_q;
        row_d   = row_q;
        done_d  = 1'b0;
        clro_d  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (bus.start) begin
                    if (bus.k_len != '0) begin
                        klast_d = bus.k_len - 1'b1;
                        k_d     = '0;
                        p_d     = '0;
                        state_d = FEED;
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end
            FEED: begin
                if (p_q == PW'(PERIOD - 1)) begin
                    p_d = '0;
                    k_d = k_q + 1'b1;
                end else begin
                    p_d = p_q + 1'b1;
                end
                if (s_last) begin
                    state_d = FLUSH;
                    f_d     = '0;
                end
            end
            FLUSH: begin
                f_d = f_q + 1'b1;
                if (f_q == FW'(F - 1)) begin
                    state_d = DRAIN;
                    row_d   = '0;
                end
            end
            DRAIN: begin
                if (beat) begin
                    if (row_q == RW'(HEIGHT - 1)) begin
                        state_d = IDLE;
                        row_d   = '0;
                        done_d  = 1'b1;
                        clro_d  = 1'b1;
                    end else begin
                        row_d = row_q + 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Skew pipe: stage i holds {s, s&first, s&last} delayed i+1 cycles.
    always_comb begin
        ps_d    = ps_q;
        pf_d    = pf_q;
        pl_d    = pl_q;
        ps_d[0] = s;
        pf_d[0] = s_first;
        pl_d[0] = s_last;
        for (int unsigned i = 1; i < DP; i++) begin
            ps_d[i] = ps_q[i-1];
            pf_d[i] = pf_q[i-1];
            pl_d[i] = pl_q[i-1];
        end
    end

    always_comb begin
        en_i_c        = '0;
        clr_i_c       = '0;
        mac_done_c    = '0;
        en_w_c        = '0;
        clr_w_c       = '0;
        en_i_c[0]     = s;
        clr_i_c[0]    = s_first;
        mac_done_c[0] = s_last;
        en_w_c[0]     = s;
        clr_w_c[0]    = s_first;
        for (int unsigned h = 1; h < HEIGHT; h++) begin
            en_i_c[h]     = ps_q[h-1];
            clr_i_c[h]    = pf_q[h-1];
            mac_done_c[h] = pl_q[h-1];
        end
        for (int unsigned w = 1; w < WIDTH; w++) begin
            en_w_c[w]  = ps_q[w-1];
            clr_w_c[w] = pf_q[w-1];
        end
    end

    assign bus.busy      = (state_q != IDLE);
    assign bus.done      = done_q;
    assign bus.en_i      = en_i_c;
    assign bus.clr_i     = clr_i_c;
    assign bus.mac_done  = mac_done_c;
    assign bus.en_w      = en_w_c;
    assign bus.clr_w     = clr_w_c;
    assign bus.en_o      = {WIDTH{beat}};
    assign bus.clr_o     = {WIDTH{clro_q}};
    assign bus.out_valid = (state_q == DRAIN);
    assign bus.out_row   = row_q;
endmodule

// File: tb/tb_sa_seq_ctrl.sv
// Bench for sa_seq_ctrl: a 4x4/PERIOD=16 and an 8x2/PERIOD=1 instance checked
// every cycle against a tile-timeline model (strobe times from t = 1 + h + k*PERIOD).
module tb_sa_seq_ctrl;
    localparam int HA = 4, WA = 4, PA = 16;
    localparam int HB = 8, WB = 2, PB = 1;
    localparam int KW = 16;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    sa_seq_ctrl_if #(.HEIGHT(HA), .WIDTH(WA), .KWIDTH(KW)) ifa ();
    sa_seq_ctrl_if #(.HEIGHT(HB), .WIDTH(WB), .KWIDTH(KW)) ifb ();

    sa_seq_ctrl #(.HEIGHT(HA), .WIDTH(WA), .PERIOD(PA), .KWIDTH(KW)) dut_a (
        .clk(clk), .rst_n(rst_n), .bus(ifa.master)
    );
    sa_seq_ctrl #(.HEIGHT(HB), .WIDTH(WB), .PERIOD(PB), .KWIDTH(KW)) dut_b (
        .clk(clk), .rst_n(rst_n), .bus(ifb.master)
    );

    logic          st[2];
    logic [KW-1:0] kl[2];
    logic          rdy[2];
    bit            rnd_rdy[2];
    bit            pat_a[$];

    assign ifa.start     = st[0];
    assign ifa.k_len     = kl[0];
    assign ifa.out_ready = rdy[0];
    assign ifb.start     = st[1];
    assign ifb.k_len     = kl[1];
    assign ifb.out_ready = rdy[1];

    int mH[2] = '{HA, HB};
    int mW[2] = '{WA, WB};
    int mP[2] = '{PA, PB};
    int mF[2] = '{HA + WA - 2 + PA, HB + WB - 2 + PB};

    bit act[2], done_n[2], clr_n[2];
    int t[2], K[2], beats[2];
    int obs_str[2], obs_beats[2];

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    endtask

    // kind 0: every strobe, 1: first-operand strobe, 2: last-operand strobe
    function automatic logic [31:0] strobe_vec(input int d, input int n, input int kind);
        logic [31:0] v;
        int e, k;
        v = '0;
        if (act[d]) begin
            for (int i = 0; i < n; i++) begin
                e = t[d] - 1 - i;
                if (e >= 0 && (e % mP[d]) == 0) begin
                    k = e / mP[d];
                    if (k < K[d] && (kind == 0 || (kind == 1 && k == 0) ||
                                     (kind == 2 && k == K[d] - 1)))
                        v[i] = 1'b1;
                end
            end
        end
        return v;
    endfunction

    function automatic bit m_valid(input int d);
        return act[d] && (t[d] >= (K[d] - 1) * mP[d] + 2 + mF[d]);
    endfunction

    task automatic m_reset();
        for (int d = 0; d < 2; d++) begin
            act[d]    = 1'b0;
            done_n[d] = 1'b0;
            clr_n[d]  = 1'b0;
        end
    endtask

    task automatic check_dut(input int d);
        logic [31:0] g_busy, g_done, g_eni, g_clri, g_md, g_enw, g_clrw;
        logic [31:0] g_eno, g_clro, g_vld, g_row, wmask;
        string n;
        bit v;
        if (d == 0) begin
            n = "A";
            g_busy = 32'(ifa.busy);  g_done = 32'(ifa.done);
            g_eni  = 32'(ifa.en_i);  g_clri = 32'(ifa.clr_i); g_md = 32'(ifa.mac_done);
            g_enw  = 32'(ifa.en_w);  g_clrw = 32'(ifa.clr_w);
            g_eno  = 32'(ifa.en_o);  g_clro = 32'(ifa.clr_o);
            g_vld  = 32'(ifa.out_valid); g_row = 32'(ifa.out_row);
        end else begin
            n = "B";
            g_busy = 32'(ifb.busy);  g_done = 32'(ifb.done);
            g_eni  = 32'(ifb.en_i);  g_clri = 32'(ifb.clr_i); g_md = 32'(ifb.mac_done);
            g_enw  = 32'(ifb.en_w);  g_clrw = 32'(ifb.clr_w);
            g_eno  = 32'(ifb.en_o);  g_clro = 32'(ifb.clr_o);
            g_vld  = 32'(ifb.out_valid); g_row = 32'(ifb.out_row);
        end
        wmask = (32'd1 << mW[d]) - 32'd1;
        v = m_valid(d);
        chk({n, ".busy"},     g_busy, 32'(act[d]));
        chk({n, ".done"},     g_done, 32'(done_n[d]));
        chk({n, ".en_i"},     g_eni,  strobe_vec(d, mH[d], 0));
        chk({n, ".clr_i"},    g_clri, strobe_vec(d, mH[d], 1));
        chk({n, ".mac_done"}, g_md,   strobe_vec(d, mH[d], 2));
        chk({n, ".en_w"},     g_enw,  strobe_vec(d, mW[d], 0));
        chk({n, ".clr_w"},    g_clrw, strobe_vec(d, mW[d], 1));
        chk({n, ".en_o"},     g_eno,  (v && rdy[d]) ? wmask : 32'd0);
        chk({n, ".clr_o"},    g_clro, clr_n[d] ? wmask : 32'd0);
        chk({n, ".out_valid"}, g_vld, 32'(v));
        if (v) chk({n, ".out_row"}, g_row, 32'(beats[d]));
        if (g_eni[0]) obs_str[d]++;
        if (g_eno != 0) obs_beats[d]++;
    endtask

    task automatic model_step(input int d);
        if (!rst_n) begin
            act[d] = 1'b0; done_n[d] = 1'b0; clr_n[d] = 1'b0;
            return;
        end
        done_n[d] = 1'b0;
        clr_n[d]  = 1'b0;
        if (act[d]) begin
            if (m_valid(d) && rdy[d]) begin
                beats[d]++;
                if (beats[d] == mH[d]) begin
                    act[d] = 1'b0; done_n[d] = 1'b1; clr_n[d] = 1'b1;
                end
            end
            t[d]++;
        end else if (st[d]) begin
            if (kl[d] != 0) begin
                act[d] = 1'b1; t[d] = 1; K[d] = int'(kl[d]); beats[d] = 0;
            end else begin
                done_n[d] = 1'b1;
            end
        end
    endtask

    // Entered and left at posedge+1; inputs for the cycle are already driven.
    task automatic run_cycle();
        for (int d = 0; d < 2; d++) begin
            if (d == 0 && pat_a.size() > 0 && m_valid(d)) rdy[d] = pat_a.pop_front();
            else if (rnd_rdy[d]) rdy[d] = 1'($urandom_range(0, 1));
            else rdy[d] = 1'b1;
        end
        @(negedge clk);
        check_dut(0);
        check_dut(1);
        model_step(0);
        model_step(1);
        @(posedge clk);
        #1;
    endtask

    task automatic start_tile(input int d, input int k);
        st[d] = 1'b1;
        kl[d] = KW'(k);
        run_cycle();
        st[d] = 1'b0;
        kl[d] = '0;
    endtask

    task automatic wait_idle(input int d, input int budget);
        int n;
        n = 0;
        while ((act[d] || done_n[d]) && n < budget) begin
            run_cycle();
            n++;
        end
        if (d == 0) chk("A.idle_after_tile", 32'(ifa.busy), 32'd0);
        else        chk("B.idle_after_tile", 32'(ifb.busy), 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0;
        for (int d = 0; d < 2; d++) begin
            st[d] = 1'b0; kl[d] = '0; rdy[d] = 1'b1; rnd_rdy[d] = 1'b0;
            obs_str[d] = 0; obs_beats[d] = 0; t[d] = 0; K[d] = 0; beats[d] = 0;
        end
        m_reset();
        #1;
        repeat (3) run_cycle();
        rst_n = 1'b1;
        repeat (3) run_cycle();

        // Single tile, K=3
        obs_str[0] = 0;
        start_tile(0, 3);
        wait_idle(0, 200);
        chk("A.k3_strobes", 32'(obs_str[0]), 32'd3);

        // Drain backpressure, K=1
        pat_a = '{1, 0, 0, 1, 1, 0, 1};
        obs_beats[0] = 0;
        start_tile(0, 1);
        wait_idle(0, 200);
        chk("A.bp_beats", 32'(obs_beats[0]), 32'd4);

        // K=0 command: done only
        obs_str[0] = 0; obs_beats[0] = 0;
        start_tile(0, 0);
        repeat (4) run_cycle();
        chk("A.k0_strobes", 32'(obs_str[0]), 32'd0);
        chk("A.k0_beats", 32'(obs_beats[0]), 32'd0);

        // start while busy is ignored
        obs_str[0] = 0;
        start_tile(0, 2);
        repeat (4) run_cycle();
        st[0] = 1'b1; kl[0] = KW'(3);
        run_cycle();
        st[0] = 1'b0; kl[0] = '0;
        wait_idle(0, 200);
        chk("A.busy_start_strobes", 32'(obs_str[0]), 32'd2);

        // Asynchronous reset mid-FLUSH
        start_tile(0, 1);
        repeat (10) run_cycle();
        rst_n = 1'b0;
        m_reset();
        #1;
        chk("A.rst_busy", 32'(ifa.busy), 32'd0);
        chk("A.rst_valid", 32'(ifa.out_valid), 32'd0);
        chk("A.rst_done", 32'(ifa.done), 32'd0);
        chk("A.rst_en_i", 32'(ifa.en_i), 32'd0);
        chk("A.rst_en_w", 32'(ifa.en_w), 32'd0);
        repeat (2) run_cycle();
        rst_n = 1'b1;
        repeat (3) run_cycle();
        obs_str[0] = 0;
        start_tile(0, 2);
        wait_idle(0, 200);
        chk("A.post_rst_strobes", 32'(obs_str[0]), 32'd2);

        // Non-square 8x2, PERIOD=1, K=4
        obs_str[1] = 0; obs_beats[1] = 0;
        start_tile(1, 4);
        wait_idle(1, 100);
        chk("B.k4_strobes", 32'(obs_str[1]), 32'd4);
        chk("B.k4_beats", 32'(obs_beats[1]), 32'd8);

        // Random commands, random backpressure, both instances
        rnd_rdy[0] = 1'b1;
        rnd_rdy[1] = 1'b1;
        for (int c = 0; c < 1500; c++) begin
            for (int d = 0; d < 2; d++) begin
                st[d] = ($urandom_range(0, 5) == 0);
                kl[d] = KW'($urandom_range(0, 4));
            end
            run_cycle();
        end
        for (int d = 0; d < 2; d++) begin
            st[d] = 1'b0;
            kl[d] = '0;
            rnd_rdy[d] = 1'b0;
        end
        wait_idle(0, 400);
        wait_idle(1, 400);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
